mac_cfg_loader: RTL and testbench

//   Drives the cfg/cset configuration interface of mac_cluster from a narrow

---
 rtl/mac_cfg_loader_if.sv | 30 +++
 rtl/mac_cfg_loader.sv | 115 +++++++++++
 tb/tb_mac_cfg_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_cfg_loader_if.sv
// Byte-stream configuration bus between the fabric and the loader, plus the
// cfg/cset pair the loader presents to a mac_cluster.
interface mac_cfg_loader_if #(
   parameter int IN_WIDTH  = 8,
   parameter int CFG_WIDTH = 132
);
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [CFG_WIDTH-1:0] cfg;
   logic                 cset;

   // master: fabric side driving beats and observing the committed word
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  cfg,
      input  cset
   );

   // slave: the loader
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output cfg,
      output cset
   );
endinterface

// File: rtl/mac_cfg_loader.sv
// Packs an LSB-first byte stream into one mac_cluster cfg word, strobes cset
// once per word and holds the cluster enable low while a load is in flight.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no load in progress, en follows en_in
//   LOAD   | at least one beat staged, waiting for the remaining beats
//   COMMIT | cfg just updated, cset high for this single cycle, no beats taken
module mac_cfg_loader #(
   parameter int MAC_CONF_WIDTH = 4,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
   parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH,
   parameter int IN_WIDTH       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_in,
   mac_cfg_loader_if.slave        bus,
   output logic                   en,
   output logic                   busy,
   output logic                   cfg_loaded
);
   localparam int CFG_WIDTH = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;
   localparam int BEATS     = (CFG_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
   localparam int STG_WIDTH = BEATS * IN_WIDTH;
   localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [STG_WIDTH-1:0]   staging_q, staging_d;
   logic [STG_WIDTH-1:0]   word;
   logic [CFG_WIDTH-1:0]   cfg_q, cfg_d;
   logic                   cset_q, cset_d;
   logic                   loaded_q, loaded_d;
   logic                   in_ready;
   logic                   accept;

   assign in_ready = (state_q != COMMIT);
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         staging_q <= '0;
         cfg_q     <= '0;
         cset_q    <= 1'b0;
         loaded_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         staging_q <= staging_d;
         cfg_q     <= cfg_d;
         cset_q    <= cset_d;
         loaded_q  <= loaded_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      staging_d = staging_q;
      cfg_d     = cfg_q;
      cset_d    = 1'b0;
      loaded_d  = loaded_q;

      // staged word with the current beat merged in at the counter's slot
      word = staging_q;
      for (int k = 0; k < BEATS; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            word[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
         end
      end

      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               staging_d = word;
               if (cnt_q == LAST_CNT) begin
                  // bits beyond CFG_WIDTH in the final beat are dropped here
                  cfg_d   = word[CFG_WIDTH-1:0];
                  cset_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = COMMIT;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         COMMIT: begin
            loaded_d = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready = in_ready;
   assign bus.cfg      = cfg_q;
   assign bus.cset     = cset_q;
   assign busy         = (state_q != IDLE);
   assign en           = en_in && !busy;
   assign cfg_loaded   = loaded_q;
endmodule

// File: tb/tb_mac_cfg_loader.sv
// Scoreboard bench for mac_cfg_loader: drivers push the expected cfg word for
// every complete load, and a negedge monitor pops and compares on each cset.
module tb_mac_cfg_loader;
   localparam int CFG_W = 132;
   localparam int BEATS = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_in = 1'b0;
   logic en, busy, cfg_loaded;

   mac_cfg_loader_if #(.IN_WIDTH(8), .CFG_WIDTH(CFG_W)) bus ();

   mac_cfg_loader dut (
      .clk        (clk),
      .rst        (rst),
      .en_in      (en_in),
      .bus        (bus),
      .en         (en),
      .busy       (busy),
      .cfg_loaded (cfg_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   logic [CFG_W-1:0] exp_q[$];
   int   cset_count = 0;
   int   cset_cyc = 0;
   int   cset_prev_cyc = 0;
   logic prev_cset = 1'b0;
   logic [CFG_W-1:0] mon_exp;

   task automatic check(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [CFG_W-1:0] pack(input logic [7:0] b[BEATS]);
      logic [BEATS*8-1:0] w;
      w = '0;
      for (int k = 0; k < BEATS; k++) w[k*8 +: 8] = b[k];
      return w[CFG_W-1:0];
   endfunction

   // monitor
   always @(negedge clk) begin
      check("in_ready_vs_cset", bus.in_ready, !bus.cset);
      if (bus.cset) begin
         check("cset_single_cycle", prev_cset, 1'b0);
         check("en_in_commit", en, 1'b0);
         if (exp_q.size() == 0) begin
            check("cset_unexpected", 1'b1, 1'b0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("cfg_at_cset", bus.cfg, mon_exp);
         end
         cset_count++;
         cset_prev_cyc = cset_cyc;
         cset_cyc = cyc;
      end
      prev_cset = bus.cset;
   end

   task automatic send_beat(input logic [7:0] d);
      logic rdy;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) return;
      end
      check("beat_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_word(input logic [7:0] b[BEATS], input int gap_after, output int c0);
      c0 = 0;
      for (int k = 0; k < BEATS; k++) begin
         if (k == gap_after) begin
            bus.in_valid = 1'b0;
            repeat (5) begin
               @(posedge clk);
               #1;
               check("en_during_gap", en, 1'b0);
            end
         end
         send_beat(b[k]);
         if (k == 0) c0 = cyc;
         check("en_during_load", en, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] b1[BEATS];
   logic [7:0] b2[BEATS];
   logic [CFG_W-1:0] w1, w2, last_word;
   int c0, cnt_before;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      en_in = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg", bus.cfg, '0);
      check("rst_cset", bus.cset, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_loaded", cfg_loaded, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_en", en, 1'b1);
      rst = 1'b0;
      idle(1);

      // word of 0x01..0x11, back-to-back
      for (int k = 0; k < BEATS; k++) b1[k] = 8'(k + 1);
      w1 = pack(b1);
      exp_q.push_back(w1);
      send_word(b1, -1, c0);
      idle(3);
      check("t1_cset_count", cset_count, 1);
      check("t1_cset_latency", cset_cyc - c0, 16);
      check("t1_cfg_lo", bus.cfg[7:0], 8'h01);
      check("t1_cfg_b15", bus.cfg[127:120], 8'h10);
      check("t1_cfg_top", bus.cfg[131:128], 4'h1);
      check("t1_loaded", cfg_loaded, 1'b1);
      check("t1_busy", busy, 1'b0);
      check("t1_en_idle", en, 1'b1);

      // same word with a 5-cycle valid gap after beat 8
      exp_q.push_back(w1);
      send_word(b1, 8, c0);
      idle(3);
      check("t2_cset_count", cset_count, 2);
      check("t2_cset_latency", cset_cyc - c0, 21);
      check("t2_cfg", bus.cfg, w1);

      // two words back-to-back, second all ones
      for (int k = 0; k < BEATS; k++) b1[k] = 8'(8'h3C ^ (k * 7));
      for (int k = 0; k < BEATS; k++) b2[k] = 8'hFF;
      w1 = pack(b1);
      w2 = pack(b2);
      exp_q.push_back(w1);
      exp_q.push_back(w2);
      send_word(b1, -1, c0);
      for (int k = 0; k < BEATS; k++) begin
         send_beat(b2[k]);
         if (k == 5) check("t3_first_cfg_between", bus.cfg, w1);
      end
      idle(3);
      check("t3_cset_count", cset_count, 4);
      check("t3_pulse_spacing", cset_cyc - cset_prev_cyc, 18);
      check("t3_cfg_all_ones", bus.cfg, {CFG_W{1'b1}});

      // reset after beat 10, then a full word of 0xA5
      cnt_before = cset_count;
      for (int k = 0; k < 10; k++) send_beat(8'(8'h30 + k));
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("t4_no_cset_on_rst", cset_count, cnt_before);
      check("t4_cfg_after_rst", bus.cfg, '0);
      check("t4_loaded_after_rst", cfg_loaded, 1'b0);
      check("t4_busy_after_rst", busy, 1'b0);
      rst = 1'b0;
      idle(1);
      for (int k = 0; k < BEATS; k++) b1[k] = 8'hA5;
      w1 = pack(b1);
      exp_q.push_back(w1);
      send_word(b1, -1, c0);
      idle(3);
      check("t4_cfg_final", bus.cfg, {4'h5, {16{8'hA5}}});
      check("t4_cset_count", cset_count, cnt_before + 1);

      // en_in toggling across IDLE, LOAD and COMMIT
      en_in = 1'b0;
      #1;
      check("t5_en_idle_lo", en, 1'b0);
      en_in = 1'b1;
      #1;
      check("t5_en_idle_hi", en, 1'b1);
      for (int k = 0; k < BEATS; k++) b1[k] = 8'(k * 16 + 3);
      w1 = pack(b1);
      last_word = w1;
      exp_q.push_back(w1);
      for (int k = 0; k < BEATS; k++) begin
         send_beat(b1[k]);
         if (k == 2) begin
            en_in = 1'b0;
            #1;
            check("t5_en_load_lo", en, 1'b0);
            en_in = 1'b1;
            #1;
            check("t5_en_load_hi", en, 1'b0);
         end
      end
      idle(3);
      check("t5_en_back_idle", en, 1'b1);
      check("t5_cset_count", cset_count, cnt_before + 2);

      // partial load then long idle
      cnt_before = cset_count;
      for (int k = 0; k < 5; k++) send_beat(8'(8'hE0 + k));
      idle(100);
      check("t6_no_cset", cset_count, cnt_before);
      check("t6_cfg_unchanged", bus.cfg, last_word);
      check("t6_busy", busy, 1'b1);
      check("t6_en_low", en, 1'b0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
